// File: rtl/decoder_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : decoder_rr_sched
// Description : Round-robin scheduler that shares a 3-to-8 decoder select path
//               between eight requesters. Arbitrates the request vector, holds
//               each grant for at most HOLD_MAX cycles and drives the decoder
//               enable/select plus the decoded one-hot grant.
// Ports       : clk   - clock, all state updates on rising edge
//               rst_n - asynchronous active-low reset
//               req   - [7:0] level request per requester
//               en    - decoder enable, 1 while a grant is active
//               i     - [2:0] decoder select (granted requester index)
//               y     - [7:0] one-hot grant, 8'h00 when en=0
//               busy  - copy of en for status/handshake
// Config      : DECODER_RR_SCHED_PRIO0_EN - when defined, requester 0 wins every
//               arbitration it requests and does not move the rotation pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_rr_sched #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic       en,
  output logic [2:0] i,
  output logic [7:0] y,
  output logic       busy
);

  localparam int              CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       i_nxt;
  logic [7:0]       y_nxt;

  logic       arb;      // an arbitration point occurs on this edge
  logic [2:0] base;     // search start for this arbitration
  logic [7:0] mask;     // request vector seen by the rotating search
  logic [3:0] found;    // {hit, index} of the rotating search
  logic       hit;
  logic [2:0] pick;

  // First set bit scanning start, start+1, ..., start+7 (mod 8).
  // Iterating downward lets the nearest candidate overwrite farther ones.
  function automatic logic [3:0] rr_search(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    i_nxt     = i;
    arb       = 1'b0;
    base      = ptr;
    mask      = req;
    hit       = 1'b0;
    pick      = 3'd0;

    case (state)
      S_IDLE: begin
        if (req != 8'h00) arb = 1'b1;
      end
      S_GRANT: begin
        if (!req[i] || (cnt == CNT_LAST)) begin
          arb = 1'b1;
`ifdef DECODER_RR_SCHED_PRIO0_EN
          if (i != 3'd0) begin
            base    = i + 3'd1;
            ptr_nxt = i + 3'd1;
          end else begin
            // Priority owner releasing: give others a turn first, rotation
            // pointer untouched so 1..7 keep their order.
            mask = req & 8'hFE;
          end
`else
          base    = i + 3'd1;
          ptr_nxt = i + 3'd1;
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    found = rr_search(mask, base);

`ifdef DECODER_RR_SCHED_PRIO0_EN
    if (mask[0]) begin
      hit  = 1'b1;
      pick = 3'd0;
    end else if (found[3]) begin
      hit  = 1'b1;
      pick = found[2:0];
    end else if (req[0]) begin
      // Only reachable when requester 0 released with nobody else waiting.
      hit  = 1'b1;
      pick = 3'd0;
    end
`else
    hit  = found[3];
    pick = found[2:0];
`endif

    if (arb) begin
      if (hit) begin
        state_nxt = S_GRANT;
        i_nxt     = pick;
        cnt_nxt   = '0;
      end else begin
        // i keeps its last value while idle
        state_nxt = S_IDLE;
      end
    end

    y_nxt = (state_nxt == S_GRANT) ? (8'd1 << i_nxt) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= 3'd0;
      cnt   <= '0;
      i     <= 3'd0;
      y     <= 8'h00;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      i     <= i_nxt;
      y     <= y_nxt;
    end
  end

  // The state flop itself is the enable register.
  assign en   = (state == S_GRANT);
  assign busy = en;

endmodule
`default_nettype wire

// File: tb/tb_decoder_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_rr_sched
// Description : Self-checking bench for decoder_rr_sched. Two instances
//               (HOLD_MAX=4 and HOLD_MAX=2) share one request vector; a
//               cycle-level grant model checks both every cycle, and literal
//               expectations pin the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_rr_sched;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req   = 8'h00;

  logic       en_a, busy_a, en_b, busy_b;
  logic [2:0] i_a, i_b;
  logic [7:0] y_a, y_b;

  int vectors    = 0;
  int miscompares = 0;

`ifdef DECODER_RR_SCHED_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  always #5 clk = ~clk;

  decoder_rr_sched #(.HOLD_MAX(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req),
    .en(en_a), .i(i_a), .y(y_a), .busy(busy_a)
  );

  decoder_rr_sched #(.HOLD_MAX(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req),
    .en(en_b), .i(i_b), .y(y_b), .busy(busy_b)
  );

  // ---------------- behavioural grant model ----------------
  int m_owner[2] = '{-1, -1};  // -1 = nobody granted
  int m_age[2]   = '{0, 0};    // cycles the owner has held so far
  int m_start[2] = '{0, 0};    // where the next rotating search begins
  int m_last[2]  = '{0, 0};    // last granted index (select holds it)

  function automatic int hold_of(input int n);
    return (n == 0) ? 4 : 2;
  endfunction

  function automatic int pick(input logic [7:0] r, input int start, input int skip);
    int b;
    for (int o = 0; o < 8; o++) begin
      b = (start + o) % 8;
      if (b != skip && r[b]) return b;
    end
    return -1;
  endfunction

  task automatic model_step(input int n, input logic [7:0] r);
    int prev, w;
    bit arb;
    prev = m_owner[n];
    arb  = 1'b0;
    w    = -1;
    if (prev < 0) arb = 1'b1;
    else if (!r[prev] || m_age[n] >= hold_of(n)) arb = 1'b1;
    else m_age[n] = m_age[n] + 1;
    if (arb) begin
      if (prev >= 0 && !(PRIO && prev == 0)) m_start[n] = (prev + 1) % 8;
      if (PRIO) begin
        if (prev == 0) begin
          w = pick(r, m_start[n], 0);
          if (w < 0 && r[0]) w = 0;
        end else if (r[0]) w = 0;
        else w = pick(r, m_start[n], -1);
      end else begin
        w = pick(r, m_start[n], -1);
      end
      m_owner[n] = w;
      if (w >= 0) begin
        m_age[n]  = 1;
        m_last[n] = w;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        m_owner[n] = -1; m_age[n] = 0; m_start[n] = 0; m_last[n] = 0;
      end
    end else begin
      for (int n = 0; n < 2; n++) model_step(n, req);
    end
  end

  function automatic logic [12:0] pack(input bit e, input int idx);
    logic [7:0] oh;
    oh = e ? 8'(1 << idx) : 8'h00;
    return {e, e, 3'(idx), oh};
  endfunction

  function automatic logic [12:0] act_of(input int n);
    return (n == 0) ? {en_a, busy_a, i_a, y_a} : {en_b, busy_b, i_b, y_b};
  endfunction

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got en/busy/i/y=%b/%b/%0d/%h expected %b/%b/%0d/%h",
               name, $time, act[12], act[11], act[10:8], act[7:0],
               exp[12], exp[11], exp[10:8], exp[7:0]);
    end
  endtask

  task automatic lit(input string name, input int n, input bit e, input int idx);
    chk(name, act_of(n), pack(e, idx));
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    chk("model_h4", act_of(0), pack(m_owner[0] >= 0, m_last[0]));
    chk("model_h2", act_of(1), pack(m_owner[1] >= 0, m_last[1]));
  end

  // Grant index of the g-th grant period under full contention.
  function automatic int contention_seq(input int g);
    if (PRIO) return (g % 2 == 0) ? 0 : ((g - 1) / 2) % 7 + 1;
    return g % 8;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] pats [9] = '{8'h24, 8'h00, 8'h81, 8'h18, 8'h7E, 8'h01, 8'hC3, 8'hFF, 8'h40};

  initial begin
    // Reset, then idle with no requests
    repeat (2) @(negedge clk);
    lit("reset_h4", 0, 1'b0, 0);
    lit("reset_h2", 1, 1'b0, 0);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      lit("idle_h4", 0, 1'b0, 0);
      lit("idle_h2", 1, 1'b0, 0);
    end

    // Single request on bit 5
    req = 8'h20;
    @(negedge clk);
    lit("single_grant_h4", 0, 1'b1, 5);
    lit("single_grant_h2", 1, 1'b1, 5);
    @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    lit("single_release_h4", 0, 1'b0, 5);
    lit("single_release_h2", 1, 1'b0, 5);

    // Full contention rotation from a fresh pointer
    do_reset();
    req = 8'hFF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      lit("rotate_h4", 0, 1'b1, contention_seq(c / 4));
      lit("rotate_h2", 1, 1'b1, contention_seq(c / 2));
    end

    // Early release by requester 7 wraps to requester 0 on the same edge
    do_reset();
    req = 8'h80;
    @(negedge clk);
    lit("wrap_own7_h4", 0, 1'b1, 7);
    lit("wrap_own7_h2", 1, 1'b1, 7);
    req = 8'h81;
    @(negedge clk);
    lit("wrap_hold7_h4", 0, 1'b1, 7);
    lit("wrap_hold7_h2", 1, 1'b1, 7);
    req = 8'h01;
    @(negedge clk);
    lit("wrap_to0_h4", 0, 1'b1, 0);
    lit("wrap_to0_h2", 1, 1'b1, 0);

    // Reset between edges while requester 3 owns the grant
    do_reset();
    req = 8'h08;
    @(negedge clk);
    lit("midrst_own3_h4", 0, 1'b1, 3);
    lit("midrst_own3_h2", 1, 1'b1, 3);
    req = 8'h0C;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    lit("midrst_async_h4", 0, 1'b0, 0);
    lit("midrst_async_h2", 1, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lit("midrst_first_h4", 0, 1'b1, 2);
    lit("midrst_first_h2", 1, 1'b1, 2);

    // Mixed request patterns, checked by the model
    for (int p = 0; p < 9; p++) begin
      req = pats[p];
      repeat (5) @(negedge clk);
    end
    req = 8'h00;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decoder_rr_sched.md
# decoder_rr_sched

Round-robin scheduler that shares the 3-to-8 decoder select path between eight requesters. It arbitrates a request vector, holds each grant for a bounded number of cycles, and drives the decoder's enable and 3-bit select, plus the decoded one-hot grant. It sits directly in front of the 3-to-8 decoder, which it sequences as a shared resource.

## Interface
- HOLD_MAX, 4: maximum consecutive cycles one requester keeps the grant; legal range 1..256.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  level request per requester; bit k = requester k.
- en  output  1  decoder enable; 1 while a grant is active.
- i  output  3  decoder select = index of granted requester.
- y  output  8  one-hot grant; y = (1 << i) when en=1, else 8'h00.
- busy  output  1  equals en; provided for status/handshake.

## Operation
- Two states: IDLE, GRANT. Internal: ptr[2:0] (search start), cnt (clog2(HOLD_MAX) bits, min 1).
- Reset (rst_n=0, asynchronous): state=IDLE, en=0, i=3'd0, y=8'h00, busy=0, ptr=3'd0, cnt=0.
- Search: the first set req bit scanning ptr, ptr+1, ..., ptr+7 (mod 8, wrap 7->0).
- IDLE: if req!=0 at an edge -> GRANT, i=search result, en=1, cnt=0. Else stay IDLE.
- GRANT, each edge, release condition = req[i]==0 OR cnt==HOLD_MAX-1:
  - No release: hold i, cnt=cnt+1.
  - Release: ptr=i+1 (mod 8); re-search from new ptr. If a requester is found, grant it this same edge with cnt=0, giving back-to-back grants with no idle cycle. The current owner may be re-granted only if no other bit is set. If none is found -> IDLE, en=0, y=0, i holds its last value.
- Simultaneous requests resolve only through rotation; no requester waits more than 7 grant periods, at most 7*HOLD_MAX cycles.
- req changes on non-owner bits during GRANT do not affect the current grant.
- HOLD_MAX=1: rotation is evaluated every cycle.

## Timing
- All outputs are registered; no combinational path from req to outputs.
- Grant latency: req sampled at edge N -> en/i/y valid after edge N.
- Owner dropping req at edge N: a new grant, or en=0, is visible after edge N. Grant ends same edge as the drop is sampled.
- Maximum continuous ownership: HOLD_MAX cycles.
- Reset mid-grant: outputs go to reset values immediately, without waiting for clk. After deassertion the first search starts at requester 0.
- y and i are always consistent in the same cycle.

## Configuration
- Macro DECODER_RR_SCHED_PRIO0_EN.
- Defined: requester 0 is priority.
  - Whenever req[0]=1 at an arbitration point (IDLE grant or release), requester 0 wins regardless of ptr.
  - Its grant is still bounded by HOLD_MAX.
  - On its release, ptr is not updated, so rotation among 1..7 is preserved.
- Not defined: pure round-robin as above, and bit 0 is an ordinary requester.

## Test plan
- Reset then idle: rst_n=0, then 1 with req=8'h00 for 10 cycles -> en=0, y=8'h00, i=0, busy=0 throughout.
- Single request: req=8'h20 held 2 cycles then 0, HOLD_MAX=4 -> after first edge en=1, i=5, y=8'h20; after release en=0, y=8'h00.
- Full contention rotation: req=8'hFF constant, HOLD_MAX=4 -> grants i=0,1,...,7,0 each lasting exactly 4 cycles, no gap cycles.
- Early release and wrap: owner i=7 with req=8'h81; drop bit 7 -> next grant i=0 on the same edge; ptr wraps to 0.
- Reset mid-grant: assert rst_n=0 between edges while en=1, i=3 -> en=0, y=0 immediately; after release with req=8'h0C, first grant is i=2.
- Macro defined: req=8'hFF, HOLD_MAX=2 -> grants i=0,1,0,2,0,3,...
- Macro undefined, same stimulus -> grants i=0,1,2,...
